// File: rtl/dsp_mac_slice.sv
// Pipelined signed multiply/pre-add/accumulate slice with valid/ready flow control.
// Modes: a*b, a*(d+/-b), ACC_LEN-sample dot-product, a*b+/-c; optional saturation.
module dsp_mac_slice #(
   parameter int A_W      = 18,
   parameter int B_W      = 18,
   parameter int P_W      = 48,
   parameter int MPIPE    = 2,
   parameter int ACC_LEN  = 8,
   parameter int SATURATE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [A_W-1:0] a,
   input  logic signed [B_W-1:0] b,
   input  logic signed [B_W-1:0] d,
   input  logic signed [P_W-1:0] c,
   input  logic [1:0]            mode,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [P_W-1:0] p,
   output logic                  ovf
);

   localparam int PR_W  = A_W + B_W + 1;
   localparam int ST_W  = 1 + 2 + 1 + P_W + PR_W;
   localparam int CNT_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;

   localparam logic [1:0] MODE_MUL = 2'b00;
   localparam logic [1:0] MODE_PRE = 2'b01;
   localparam logic [1:0] MODE_DOT = 2'b10;
   localparam logic [1:0] MODE_MAC = 2'b11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
   localparam logic [P_W-1:0]   P_MAX    = {1'b0, {(P_W-1){1'b1}}};
   localparam logic [P_W-1:0]   P_MIN    = {1'b1, {(P_W-1){1'b0}}};

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic signed [B_W:0]    pre_in;
   logic signed [PR_W-1:0] a_x;
   logic signed [PR_W-1:0] pre_x;
   logic signed [PR_W-1:0] prod_in;
   logic [ST_W-1:0]        st_in;

   // The multiply is formed from the raw operands so the first pipeline register already holds the product.
   always_comb begin
      pre_in = {b[B_W-1], b};
      if (mode == MODE_PRE) begin
         if (sub) pre_in = {d[B_W-1], d} - {b[B_W-1], b};
         else     pre_in = {d[B_W-1], d} + {b[B_W-1], b};
      end
      a_x     = {{(B_W+1){a[A_W-1]}}, a};
      pre_x   = {{A_W{pre_in[B_W]}}, pre_in};
      prod_in = a_x * pre_x;
      st_in   = {in_valid, mode, sub, c, prod_in};
   end

   logic [ST_W-1:0] pipe_reg [MPIPE];

   genvar gi;
   generate
      for (gi = 0; gi < MPIPE; gi++) begin : g_pipe
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst)          pipe_reg[gi] <= '0;
               else if (advance) pipe_reg[gi] <= st_in;
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (rst)          pipe_reg[gi] <= '0;
               else if (advance) pipe_reg[gi] <= pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   logic                  fin_valid;
   logic [1:0]            fin_mode;
   logic                  fin_sub;
   logic signed [P_W-1:0] fin_c;
   logic signed [PR_W-1:0] fin_prod;
   assign {fin_valid, fin_mode, fin_sub, fin_c, fin_prod} = pipe_reg[MPIPE-1];

   logic signed [P_W-1:0] acc_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic signed [P_W:0]   prod_ext;
   logic signed [P_W:0]   c_ext;
   logic signed [P_W:0]   acc_ext;
   logic signed [P_W:0]   sum;
   logic                  over;
   logic signed [P_W-1:0] res;

   // One guard bit above P_W exposes overflow as a disagreement of the top two bits.
   always_comb begin
      prod_ext = {{(P_W+1-PR_W){fin_prod[PR_W-1]}}, fin_prod};
      c_ext    = {fin_c[P_W-1], fin_c};
      acc_ext  = {acc_reg[P_W-1], acc_reg};
      case (fin_mode)
         MODE_DOT: sum = (cnt_reg == '0) ? prod_ext : acc_ext + prod_ext;
         MODE_MAC: sum = fin_sub ? prod_ext - c_ext : prod_ext + c_ext;
         default:  sum = prod_ext;
      endcase
      over = sum[P_W] ^ sum[P_W-1];
      res  = sum[P_W-1:0];
      if (over && SATURATE != 0) res = sum[P_W] ? P_MIN : P_MAX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         p         <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         ovf       <= 1'b0;
      end else if (advance) begin
         out_valid <= 1'b0;
         if (fin_valid) begin
            if (over) ovf <= 1'b1;
            if (fin_mode == MODE_DOT) begin
               acc_reg <= res;
               if (cnt_reg == CNT_LAST) begin
                  p         <= res;
                  out_valid <= 1'b1;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end else begin
               p         <= res;
               out_valid <= 1'b1;
               // A non-accumulate sample interrupting a dot-product throws the partial sum away.
               if (cnt_reg != '0) begin
                  cnt_reg <= '0;
                  acc_reg <= '0;
                  ovf     <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: default instance plus two 38-bit instances
// (saturating and wrapping) sharing the same stimulus.
module tb_dsp_mac_slice;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [17:0] a, b, d;
   logic signed [47:0] c;
   logic [1:0]         mode;
   logic               sub;
   logic               out_ready;

   logic               in_ready_m, out_valid_m, ovf_m;
   logic signed [47:0] p_m;
   logic               in_ready_s, out_valid_s, ovf_s;
   logic signed [37:0] p_s;
   logic               in_ready_w, out_valid_w, ovf_w;
   logic signed [37:0] p_w;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   dsp_mac_slice dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
      .a(a), .b(b), .d(d), .c(c), .mode(mode), .sub(sub),
      .out_valid(out_valid_m), .out_ready(out_ready), .p(p_m), .ovf(ovf_m)
   );

   dsp_mac_slice #(.P_W(38), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .d(d), .c(c[37:0]), .mode(mode), .sub(sub),
      .out_valid(out_valid_s), .out_ready(out_ready), .p(p_s), .ovf(ovf_s)
   );

   dsp_mac_slice #(.P_W(38), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .d(d), .c(c[37:0]), .mode(mode), .sub(sub),
      .out_valid(out_valid_w), .out_ready(out_ready), .p(p_w), .ovf(ovf_w)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
         $display("check %s = %0d", tag, obs);
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input logic s, input int av, input int bv,
                        input int dv, input longint cv);
      mode     = m;
      sub      = s;
      a        = 18'(av);
      b        = 18'(bv);
      d        = 18'(dv);
      c        = 48'(cv);
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [1:0] m, input logic s, input int av, input int bv,
                       input int dv, input longint cv);
      drive(m, s, av, bv, dv, cv);
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; d = '0; c = '0; mode = 2'b00; sub = 1'b0;
      step(); step();
      chk("rst_out_valid", out_valid_m, 0);
      chk("rst_p", p_m, 0);
      chk("rst_ovf", ovf_m, 0);
      rst = 1'b0;
      step();
      chk("rst_in_ready", in_ready_m, 1);

      // mode 00: 3 * -4, result three edges after acceptance
      send(2'b00, 0, 3, -4, 0, 0);
      idle();
      chk("m00_lat1", out_valid_m, 0);
      step();
      chk("m00_lat2", out_valid_m, 0);
      step();
      chk("m00_valid", out_valid_m, 1);
      chk("m00_p", p_m, -12);
      step();
      chk("m00_pulse_end", out_valid_m, 0);

      // mode 01 sub: 5*(10-3); mode 11 sub: 2*7-100
      send(2'b01, 1, 5, 3, 10, 0);
      send(2'b11, 1, 2, 7, 0, 100);
      idle();
      step();
      chk("m01_valid", out_valid_m, 1);
      chk("m01_p", p_m, 35);
      step();
      chk("m11_valid", out_valid_m, 1);
      chk("m11_p", p_m, -86);
      step();
      chk("m11_pulse_end", out_valid_m, 0);

      // dot-product: sum of (i+1)*2 for i=0..7 = 72
      for (int i = 0; i < 8; i++) begin
         send(2'b10, 0, i + 1, 2, 0, 0);
         chk($sformatf("dot_quiet_%0d", i), out_valid_m, 0);
      end
      idle();
      step();
      chk("dot_quiet_8", out_valid_m, 0);
      step();
      chk("dot_valid", out_valid_m, 1);
      chk("dot_p", p_m, 72);
      step();
      chk("dot_pulse_end", out_valid_m, 0);

      // second run must start from zero: 8 * 1*1
      for (int i = 0; i < 8; i++) send(2'b10, 0, 1, 1, 0, 0);
      idle();
      step(); step();
      chk("dot2_valid", out_valid_m, 1);
      chk("dot2_p", p_m, 8);
      step();

      // backpressure: three accepted while stalled, two more offered
      out_ready = 1'b0;
      send(2'b00, 0, 1, 10, 0, 0);
      send(2'b00, 0, 2, 10, 0, 0);
      send(2'b00, 0, 3, 10, 0, 0);
      chk("bp_in_ready_low", in_ready_m, 0);
      drive(2'b00, 0, 4, 10, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_stall_ready_%0d", i), in_ready_m, 0);
         chk($sformatf("bp_stall_p_%0d", i), p_m, 10);
      end
      out_ready = 1'b1;
      step();
      chk("bp_drain_20", p_m, 20);
      drive(2'b00, 0, 5, 10, 0, 0);
      step();
      chk("bp_drain_30", p_m, 30);
      idle();
      step();
      chk("bp_drain_40", p_m, 40);
      step();
      chk("bp_drain_50", p_m, 50);
      chk("bp_drain_50_valid", out_valid_m, 1);
      step();
      chk("bp_drain_end", out_valid_m, 0);

      // overflow: 8 * 2^34 = 2^37 exceeds a 38-bit signed range
      for (int i = 0; i < 8; i++) send(2'b10, 0, -131072, -131072, 0, 0);
      idle();
      step(); step();
      chk("sat_valid", out_valid_s, 1);
      chk("sat_p", p_s, (longint'(1) <<< 37) - 1);
      chk("sat_ovf", ovf_s, 1);
      chk("wrap_p", p_w, -(longint'(1) <<< 37));
      chk("wrap_ovf", ovf_w, 1);
      chk("wide_p", p_m, longint'(1) <<< 37);
      chk("wide_ovf", ovf_m, 0);
      step();

      // interrupted dot-product: partial discarded, ovf set
      for (int i = 0; i < 3; i++) send(2'b10, 0, 1, 1, 0, 0);
      send(2'b00, 0, 2, 3, 0, 0);
      idle();
      step();
      chk("abort_quiet", out_valid_m, 0);
      step();
      chk("abort_valid", out_valid_m, 1);
      chk("abort_p", p_m, 6);
      chk("abort_ovf", ovf_m, 1);
      for (int i = 0; i < 8; i++) send(2'b10, 0, 1, 5, 0, 0);
      idle();
      step(); step();
      chk("abort_restart_valid", out_valid_m, 1);
      chk("abort_restart_p", p_m, 40);
      step();

      // reset mid dot-product; in_valid held during reset must be ignored
      for (int i = 0; i < 3; i++) send(2'b10, 0, 100, 1, 0, 0);
      rst = 1'b1;
      drive(2'b10, 0, 100, 1, 0, 0);
      step();
      chk("mrst_out_valid", out_valid_m, 0);
      chk("mrst_ovf", ovf_m, 0);
      chk("mrst_ovf_sat", ovf_s, 0);
      chk("mrst_p", p_m, 0);
      rst = 1'b0;
      idle();
      step();
      chk("mrst_in_ready", in_ready_m, 1);
      for (int i = 0; i < 8; i++) send(2'b10, 0, 1, 3, 0, 0);
      idle();
      step();
      chk("mrst_quiet", out_valid_m, 0);
      step();
      chk("mrst_valid", out_valid_m, 1);
      chk("mrst_p_fresh", p_m, 24);
      step();
      chk("mrst_pulse_end", out_valid_m, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dsp_mac_slice.md
DSP_MAC_SLICE -- requirements
Module: dsp_mac_slice

Interface
REQ-001 SHALL have parameter A_W, default 18: signed width of a.
REQ-002 SHALL have parameter B_W, default 18: signed width of b and d.
REQ-003 SHALL have parameter P_W, default 48: signed width of c and p; legal values are P_W >= A_W+B_W+2.
REQ-004 SHALL have parameter MPIPE, default 2: multiplier pipeline stages; legal range 1..4.
REQ-005 SHALL have parameter ACC_LEN, default 8: samples per dot-product; legal values are >= 2.
REQ-006 SHALL have parameter SATURATE, default 1: 1 = clamp result, 0 = wrap.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-010 SHALL have port in_ready, output, 1 bit: slice accepts a sample this cycle.
REQ-011 SHALL have ports a (A_W), b (B_W), d (B_W) and c (P_W), inputs: signed operands.
REQ-012 SHALL have port mode, input, 2 bits: 00 a*b; 01 a*(d+b); 10 dot-product; 11 a*b+c.
REQ-013 SHALL have port sub, input, 1 bit: in modes 01 and 11, 1 selects d-b and a*b-c respectively.
REQ-014 SHALL have port out_valid, output, 1 bit: result present on p.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 SHALL have port p, output, P_W bits: signed result.
REQ-017 SHALL have port ovf, output, 1 bit: sticky overflow/saturation flag.

Function
REQ-018 SHALL define advance = !out_valid || out_ready, and SHALL drive in_ready = advance.
- A sample is accepted when in_valid && in_ready.
REQ-019 SHALL capture a, b, d, c, mode and sub together with each accepted sample and carry them down the pipeline.
- Later input changes SHALL NOT affect a sample already in flight.
REQ-020 SHALL freeze every pipeline stage, including valid bits, while advance = 0.
- No sample SHALL be lost or duplicated.
REQ-021 SHALL compute the pre-add at B_W+1 bits.
- Product at A_W+B_W+1 bits, sign-extended to P_W before add/accumulate.
REQ-022 SHALL present the result in modes 00, 01 and 11 on p with out_valid = 1 exactly MPIPE+1 advancing cycles after acceptance.
- Throughput SHALL be 1 sample per cycle while out_ready = 1.
REQ-023 SHALL implement dot-product (mode 10) with a sample counter 0..ACC_LEN-1 and an accumulator register.
- Count 0: the accumulator loads the product.
- Other counts: the accumulator adds the product.
- Count ACC_LEN-1: the sum is emitted on p with out_valid and the counter wraps to 0.
- Intermediate samples SHALL NOT raise out_valid.
REQ-024 SHALL restart the counter from 0 with the accumulator reloaded when a sample with mode != 10 arrives at the accumulate stage mid-dot-product.
- The partial sum SHALL be discarded and ovf set.
REQ-025 SHALL clamp on overflow when SATURATE=1: p = 2^(P_W-1)-1 on positive overflow, -2^(P_W-1) on negative overflow.
- When SATURATE=0, p SHALL wrap modulo 2^P_W.
- In both cases ovf SHALL be set.
REQ-026 SHALL let a saturated accumulator value continue as the clamped value in dot-product mode.
REQ-027 SHALL clear ovf only on rst.

Reset
REQ-028 SHALL, while rst=1 at a clock edge:
- clear all pipeline valid bits, the counter, the accumulator, p and ovf to 0;
- set out_valid=0;
- drive in_ready to 1 from the following cycle.
REQ-029 SHALL discard all in-flight samples and any partial dot-product when rst is asserted mid-operation.
REQ-030 SHALL ignore in_valid during a cycle with rst=1.

Verification
REQ-031 SHALL cover: defaults, mode 00, a=3, b=-4 accepted at cycle 0, out_ready=1 -> p=-12, out_valid=1 at cycle 3 only.
REQ-032 SHALL cover: mode 01, sub=1, a=5, d=10, b=3 -> p=35; then mode 11, sub=1, a=2, b=7, c=100 -> p=-86 on the next cycle.
REQ-033 SHALL cover: mode 10, ACC_LEN=8, eight back-to-back samples a=i+1, b=2 for i=0..7 -> single out_valid pulse, p=72, then the next sum starts from 0.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with results pending -> in_ready=0, p stable, no sample lost; 5 queued results drain in order after release.
REQ-035 SHALL cover: P_W=38, SATURATE=1, mode 10, a=b=-131072 repeated -> p clamps to 2^37-1, ovf=1; same with SATURATE=0 -> wrapped value, ovf=1.
REQ-036 SHALL cover: rst asserted after 3 of 8 dot-product samples -> out_valid=0, ovf=0; a fresh 8-sample run yields a sum excluding the pre-reset samples.
